// File: rtl/l1_refill_ctrl_pkg.sv
// Shared definitions for the L1 refill / uncached access controller:
// state encoding, bus beat geometry and access-size one-hot codes.
package l1_refill_ctrl_pkg;

    // Bus beat geometry: the data path is 64 bits wide.
    localparam int BEAT_BYTES     = 8;
    localparam int BEAT_OFS_W     = $clog2(BEAT_BYTES);

    // Default line geometry; addr_count carries a byte offset inside a line.
    localparam int LINE_BYTES_DEF = 2048;
    localparam int CNT_W          = $clog2(LINE_BYTES_DEF);

    // Access size one-hot codes shared by L1_size and bus_size.
    localparam logic [3:0] SIZE_1B = 4'b0001;
    localparam logic [3:0] SIZE_2B = 4'b0010;
    localparam logic [3:0] SIZE_4B = 4'b0100;
    localparam logic [3:0] SIZE_8B = 4'b1000;

    // State encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LINE_RD  = 3'd1;
    localparam logic [2:0] ST_LINE_UPD = 3'd2;
    localparam logic [2:0] ST_SGL_RD   = 3'd3;
    localparam logic [2:0] ST_SGL_WR   = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_ERR      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LINE_RD  = ST_LINE_RD,
        S_LINE_UPD = ST_LINE_UPD,
        S_SGL_RD   = ST_SGL_RD,
        S_SGL_WR   = ST_SGL_WR,
        S_DONE     = ST_DONE,
        S_ERR      = ST_ERR
    } state_t;

    // Byte count of a one-hot access size; unknown codes read as zero.
    function automatic int unsigned size_bytes(input logic [3:0] size);
        int unsigned n;
        n = 0;
        case (size)
            SIZE_1B: n = 1;
            SIZE_2B: n = 2;
            SIZE_4B: n = 4;
            SIZE_8B: n = 8;
            default: n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/l1_refill_ctrl.sv
// L1 refill controller: turns L1 line-refill, uncached-read and write-through
// requests into beats on a req/ack bus and reports results back to the L1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an L1 request (requests sampled only here)
// LINE_RD  | streaming line beats; each ack writes one beat into the L1
// LINE_UPD | last beat's line_write plus the tag/valid commit pulse
// SGL_RD   | single uncached read beat outstanding
// SGL_WR   | single write-through beat outstanding
// DONE     | trans_rdy pulse, back to IDLE
// ERR      | bus_error pulse (bus_err or timeout), back to IDLE
module l1_refill_ctrl
    import l1_refill_ctrl_pkg::*;
#(
    parameter int LINE_BYTES  = LINE_BYTES_DEF,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read_line_req,
    input  logic                          read_req,
    input  logic                          write_through_req,
    input  logic [3:0]                    L1_size,
    input  logic [63:0]                   pa,
    input  logic [63:0]                   wt_data,
    output logic [63:0]                   line_data,
    output logic [$clog2(LINE_BYTES)-1:0] addr_count,
    output logic                          line_write,
    output logic                          cache_entry_write,
    output logic                          trans_rdy,
    output logic                          bus_error,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [63:0]                   bus_addr,
    output logic [3:0]                    bus_size,
    output logic [63:0]                   bus_wdata,
    input  logic [63:0]                   bus_rdata,
    input  logic                          bus_ack,
    input  logic                          bus_err
);

    localparam int AC_W      = $clog2(LINE_BYTES);
    localparam int BEAT_W    = AC_W - BEAT_OFS_W;
    localparam int NUM_BEATS = LINE_BYTES / BEAT_BYTES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    // Timeout counter sized to hold TIMEOUT_CYC; a zero limit disables it.
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

    state_t               r_state;
    logic [BEAT_W-1:0]    r_beat;
    logic [TO_W-1:0]      r_tcnt;
    logic [63-AC_W:0]     r_line_base;

    logic [BEAT_W-1:0]    w_beat_nxt;
    logic [TO_W-1:0]      w_tcnt_nxt;
    logic                 w_last_beat;
    logic                 w_timeout;
    logic                 w_fail;

    assign w_beat_nxt  = r_beat + 1'b1;
    assign w_tcnt_nxt  = r_tcnt + 1'b1;
    assign w_last_beat = (r_beat == LAST_BEAT);
    // The wait that would bring the counter to the limit ends the request.
    assign w_timeout   = TO_EN && (w_tcnt_nxt == TO_LIM);
    // bus_err beats a simultaneous ack; a timeout only counts without an ack.
    assign w_fail      = bus_err || (!bus_ack && w_timeout);

    // Request sequencing FSM with all L1 and bus outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_beat            <= '0;
            r_tcnt            <= '0;
            r_line_base       <= '0;
            line_data         <= '0;
            addr_count        <= '0;
            line_write        <= 1'b0;
            cache_entry_write <= 1'b0;
            trans_rdy         <= 1'b0;
            bus_error         <= 1'b0;
            bus_req           <= 1'b0;
            bus_we            <= 1'b0;
            bus_addr          <= '0;
            bus_size          <= '0;
            bus_wdata         <= '0;
        end else begin
            line_write        <= 1'b0;
            cache_entry_write <= 1'b0;
            trans_rdy         <= 1'b0;
            bus_error         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    r_tcnt <= '0;
                    if (read_line_req) begin
                        r_state     <= S_LINE_RD;
                        r_line_base <= pa[63:AC_W];
                        bus_req     <= 1'b1;
                        bus_we      <= 1'b0;
                        bus_size    <= SIZE_8B;
                        bus_addr    <= {pa[63:AC_W], {AC_W{1'b0}}};
                    end else if (read_req) begin
                        r_state  <= S_SGL_RD;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_size <= L1_size;
                        bus_addr <= pa;
                    end else if (write_through_req) begin
                        r_state   <= S_SGL_WR;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_size  <= L1_size;
                        bus_addr  <= pa;
                        bus_wdata <= wt_data;
                    end
                end

                S_LINE_RD, S_SGL_RD, S_SGL_WR: begin
                    if (w_fail) begin
                        r_state   <= S_ERR;
                        r_tcnt    <= '0;
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                    end else if (bus_ack) begin
                        r_tcnt <= '0;
                        if (r_state == S_LINE_RD) begin
                            line_write <= 1'b1;
                            line_data  <= bus_rdata;
                            addr_count <= {r_beat, {BEAT_OFS_W{1'b0}}};
                            if (w_last_beat) begin
                                // Beat counter is left at the last beat; IDLE clears it.
                                r_state           <= S_LINE_UPD;
                                bus_req           <= 1'b0;
                                cache_entry_write <= 1'b1;
                            end else begin
                                r_beat   <= w_beat_nxt;
                                bus_addr <= {r_line_base, w_beat_nxt, {BEAT_OFS_W{1'b0}}};
                            end
                        end else begin
                            if (r_state == S_SGL_RD) begin
                                line_data <= bus_rdata;
                            end
                            r_state   <= S_DONE;
                            bus_req   <= 1'b0;
                            trans_rdy <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= w_tcnt_nxt;
                    end
                end

                S_LINE_UPD: begin
                    r_state   <= S_DONE;
                    trans_rdy <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Bench for l1_refill_ctrl: directed L1 requests against a scripted bus
// responder, with a timeline model of the expected outputs checked every cycle.
module tb_l1_refill_ctrl;

    localparam int LB = 2048;
    localparam int TO = 8;
    localparam int NB = LB / 8;
    localparam int K_LINE = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_line_req = 1'b0;
    logic        read_req = 1'b0;
    logic        write_through_req = 1'b0;
    logic [3:0]  L1_size = 4'b0000;
    logic [63:0] pa = '0;
    logic [63:0] wt_data = '0;
    logic [63:0] line_data;
    logic [10:0] addr_count;
    logic        line_write;
    logic        cache_entry_write;
    logic        trans_rdy;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [3:0]  bus_size;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;

    l1_refill_ctrl #(.LINE_BYTES(LB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .read_line_req(read_line_req), .read_req(read_req),
        .write_through_req(write_through_req),
        .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
        .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
        .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy),
        .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_size(bus_size), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // Tracks the outstanding transaction and the cycle numbers at which each
    // pulse output is due, derived from the acks/errors the bus delivered.
    int          cyc = 0;
    bit          m_on = 0;
    bit          m_zero = 1;
    int          m_kind = 0;
    int          m_acks = 0;
    int          m_wait = 0;
    int          m_idle_from = 0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_ld = '0;
    logic [3:0]  m_size = '0;
    logic [10:0] m_ac = '0;
    int          t_lw = -1, t_cew = -1, t_rdy = -1, t_err = -1;

    task automatic model_step();
        if (!rst) begin
            m_on = 0; m_zero = 1; m_ld = '0; m_ac = '0;
            t_lw = -1; t_cew = -1; t_rdy = -1; t_err = -1;
            m_idle_from = cyc + 1;
        end else if (m_on) begin
            if (bus_err) begin
                m_on = 0; t_err = cyc; m_idle_from = cyc + 2;
            end else if (bus_ack) begin
                m_wait = 0;
                if (m_kind == K_LINE) begin
                    t_lw = cyc;
                    m_ld = bus_rdata;
                    m_ac = 11'(m_acks * 8);
                    m_acks++;
                    if (m_acks == NB) begin
                        m_on = 0; t_cew = cyc; t_rdy = cyc + 1; m_idle_from = cyc + 3;
                    end
                end else begin
                    if (m_kind == K_RD) m_ld = bus_rdata;
                    m_on = 0; t_rdy = cyc; m_idle_from = cyc + 2;
                end
            end else begin
                m_wait++;
                if (TO != 0 && m_wait == TO) begin
                    m_on = 0; t_err = cyc; m_idle_from = cyc + 2;
                end
            end
        end else if (cyc >= m_idle_from && (read_line_req || read_req || write_through_req)) begin
            m_on = 1; m_zero = 0; m_wait = 0; m_acks = 0;
            if (read_line_req) begin
                m_kind = K_LINE; m_addr = pa & ~64'(LB - 1); m_size = 4'b1000;
            end else if (read_req) begin
                m_kind = K_RD; m_addr = pa; m_size = L1_size;
            end else begin
                m_kind = K_WR; m_addr = pa; m_size = L1_size; m_wdata = wt_data;
            end
        end
    endtask

    task automatic compare();
        chk("bus_req", bus_req, m_on);
        if (m_on) begin
            chk("bus_addr", bus_addr, m_addr + 64'(m_acks) * 8);
            chk("bus_size", bus_size, m_size);
            chk("bus_we", bus_we, m_kind == K_WR);
            if (m_kind == K_WR) chk("bus_wdata", bus_wdata, m_wdata);
        end else if (m_zero) begin
            chk("bus_addr_rst", bus_addr, 0);
            chk("bus_ctl_rst", {bus_we, bus_size}, 0);
            chk("bus_wdata_rst", bus_wdata, 0);
        end
        chk("line_write", line_write, t_lw == cyc);
        chk("cache_entry_write", cache_entry_write, t_cew == cyc);
        chk("trans_rdy", trans_rdy, t_rdy == cyc);
        chk("bus_error", bus_error, t_err == cyc);
        chk("line_data", line_data, m_ld);
        chk("addr_count", addr_count, m_ac);
    endtask

    // Model advances on each edge; outputs are compared mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            compare();
        end
    end

    // ---------------- stimulus / bus responder ----------------
    bit          resp_on = 0;
    bit          rd_fixed = 0;
    int          resp_delay = 0;
    int          err_beat = -1;
    int          rwait = 0, rbeat = 0;
    int          lw_n, cew_n, rdy_n, err_n, idx, rdy_idx, err_idx;
    bit          seen_req;
    bit          seen_we;
    logic [3:0]  seen_size;
    logic [63:0] first_addr, last_addr, seen_wdata, rdy_ld;
    logic [10:0] last_ac;

    task automatic clear_obs();
        lw_n = 0; cew_n = 0; rdy_n = 0; err_n = 0; idx = 0;
        rdy_idx = -1; err_idx = -1; seen_req = 0; seen_we = 0;
        seen_size = '0; first_addr = '0; last_addr = '0; seen_wdata = '0;
        rdy_ld = '0; last_ac = '0; rwait = 0; rbeat = 0;
    endtask

    // One clock: observe the cycle just begun, act as the L1 and as the bus.
    task automatic tick();
        @(posedge clk);
        #1;
        if (seen_req) idx++;
        if (bus_req && !seen_req) begin
            seen_req = 1; idx = 0; first_addr = bus_addr;
        end
        if (bus_req) begin
            last_addr = bus_addr; seen_size = bus_size;
            seen_we = bus_we; seen_wdata = bus_wdata;
        end
        if (line_write) begin lw_n++; last_ac = addr_count; end
        if (cache_entry_write) cew_n++;
        if (trans_rdy) begin rdy_n++; rdy_idx = idx; rdy_ld = line_data; end
        if (bus_error) begin err_n++; err_idx = idx; end
        if (trans_rdy || bus_error) begin
            read_line_req = 0; read_req = 0; write_through_req = 0;
        end
        if (resp_on) begin
            bus_ack = 0; bus_err = 0;
            if (bus_req) begin
                if (rwait >= resp_delay) begin
                    if (rbeat == err_beat) bus_err = 1;
                    else begin
                        bus_ack = 1;
                        bus_rdata = rd_fixed ? 64'hDEAD_BEEF
                                             : {32'hC0FF_EE00 ^ 32'(rbeat), bus_addr[31:0]};
                    end
                    rbeat++; rwait = 0;
                end else begin
                    rwait++;
                end
            end
        end
    endtask

    task automatic run(input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (rdy_n != 0 || err_n != 0) break;
        end
        chk("txn_end_events", rdy_n + err_n, 1);
        tick();
        tick();
    endtask

    initial begin
        clear_obs();
        tick();
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_line_write", line_write, 0);
        chk("rst_line_data", line_data, 0);
        chk("rst_trans_rdy", trans_rdy, 0);
        rst = 1;
        tick();

        // Full line refill, zero-wait bus.
        clear_obs(); resp_on = 1; resp_delay = 0; err_beat = -1; rd_fixed = 0;
        pa = 64'h8000_0A38; read_line_req = 1;
        run(400);
        chk("t1_first_addr", first_addr, 64'h8000_0800);
        chk("t1_last_addr", last_addr, 64'h8000_0FF8);
        chk("t1_line_writes", lw_n, 256);
        chk("t1_last_addr_count", last_ac, 11'h7F8);
        chk("t1_cache_entry_writes", cew_n, 1);
        chk("t1_trans_rdy_count", rdy_n, 1);
        chk("t1_rdy_cycle", rdy_idx, 257);

        // Uncached read, ack after 3 wait cycles.
        clear_obs(); resp_delay = 3; rd_fixed = 1;
        pa = 64'h1000_0004; L1_size = 4'b0100; read_req = 1;
        run(40);
        chk("t2_bus_addr", first_addr, 64'h1000_0004);
        chk("t2_bus_size", seen_size, 4'b0100);
        chk("t2_line_data", rdy_ld, 64'hDEAD_BEEF);
        chk("t2_line_writes", lw_n, 0);
        chk("t2_rdy_cycle", rdy_idx, 4);

        // Write-through, zero-wait.
        clear_obs(); resp_delay = 0; rd_fixed = 0;
        pa = 64'h4000_0102; L1_size = 4'b0010; wt_data = 64'h55AA; write_through_req = 1;
        run(40);
        chk("t3_bus_we", seen_we, 1);
        chk("t3_bus_wdata", seen_wdata, 64'h55AA);
        chk("t3_trans_rdy_count", rdy_n, 1);
        chk("t3_rdy_cycle", rdy_idx, 1);

        // Line refill with bus_err on beat 17.
        clear_obs(); err_beat = 17;
        pa = 64'h0000_0001_2345_6000; read_line_req = 1;
        run(400);
        chk("t4_bus_error_count", err_n, 1);
        chk("t4_cache_entry_writes", cew_n, 0);
        chk("t4_line_writes", lw_n, 17);
        chk("t4_err_cycle", err_idx, 18);
        chk("t4_idle_bus_req", bus_req, 0);
        err_beat = -1;

        // No response at all: timeout after TO cycles.
        clear_obs(); resp_on = 0; bus_ack = 0; bus_err = 0;
        pa = 64'h2000_0010; L1_size = 4'b0001; read_req = 1;
        run(40);
        chk("t5_bus_error_count", err_n, 1);
        chk("t5_trans_rdy_count", rdy_n, 0);
        chk("t5_err_cycle", err_idx, 8);
        chk("t5_bus_req_after", bus_req, 0);

        // Reset in the middle of a refill, then a stray ack.
        clear_obs(); resp_on = 1; resp_delay = 0;
        pa = 64'h1234_5000; read_line_req = 1;
        for (int i = 0; i < 300 && rbeat < 100; i++) tick();
        resp_delay = 100000;
        read_line_req = 0;
        tick();
        chk("t6_beat100_addr", bus_addr, 64'h1234_5320);
        chk("t6_beat100_req", bus_req, 1);
        resp_on = 0; bus_ack = 0; rst = 0;
        tick();
        chk("t6_rst_bus_req", bus_req, 0);
        chk("t6_rst_line_write", line_write, 0);
        chk("t6_rst_line_data", line_data, 0);
        chk("t6_rst_addr_count", addr_count, 0);
        chk("t6_rst_bus_addr", bus_addr, 0);
        rst = 1; bus_ack = 1; bus_rdata = 64'h0BAD_0BAD; lw_n = 0;
        tick(); tick(); tick();
        chk("t6_late_ack_line_writes", lw_n, 0);
        bus_ack = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
